// File: rtl/turn_signal_conditioner.sv
// Turn-switch front end: synchronizes and debounces the left/right switches,
// flags accepted rising levels with one-cycle pulses, and emits a free-running step tick.
module turn_signal_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left,
    output logic right,
    output logic left_rise,
    output logic right_rise,
    output logic tick
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    // With a one-cycle debounce the very first sample that differs is accepted.
    localparam logic SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        PEND1   = 2'd1,
        STABLE1 = 2'd2,
        PEND0   = 2'd3
    } db_state_t;

    logic [1:0]        raw_s;
    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    db_state_t         state_r [2];
    db_state_t         state_s [2];
    logic [CNT_W-1:0]  cnt_r [2];
    logic [CNT_W-1:0]  cnt_s [2];
    logic [1:0]        level_r;
    logic [1:0]        level_s;
    logic [1:0]        rise_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [TICK_W-1:0] tick_cnt_s;
    logic              tick_r;

    assign raw_s = {right_raw, left_raw};

    // Two-flop synchronizers, channel 0 = left, channel 1 = right.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state logic for both channels, plus tick counter wrap.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_s[ch] = state_r[ch];
            cnt_s[ch]   = cnt_r[ch];
            level_s[ch] = level_r[ch];
            case (state_r[ch])
                STABLE0: begin
                    if (sync2_r[ch] && SINGLE_SAMPLE) begin
                        state_s[ch] = STABLE1;
                        cnt_s[ch]   = CNT_ZERO;
                        level_s[ch] = 1'b1;
                    end else if (sync2_r[ch]) begin
                        state_s[ch] = PEND1;
                        cnt_s[ch]   = CNT_ONE;
                    end else begin
                        cnt_s[ch]   = CNT_ZERO;
                    end
                end
                PEND1: begin
                    if (sync2_r[ch] && (cnt_r[ch] == CNT_LAST)) begin
                        state_s[ch] = STABLE1;
                        cnt_s[ch]   = CNT_ZERO;
                        level_s[ch] = 1'b1;
                    end else if (sync2_r[ch]) begin
                        cnt_s[ch]   = cnt_r[ch] + CNT_ONE;
                    end else begin
                        state_s[ch] = STABLE0;
                        cnt_s[ch]   = CNT_ZERO;
                    end
                end
                STABLE1: begin
                    if (!sync2_r[ch] && SINGLE_SAMPLE) begin
                        state_s[ch] = STABLE0;
                        cnt_s[ch]   = CNT_ZERO;
                        level_s[ch] = 1'b0;
                    end else if (!sync2_r[ch]) begin
                        state_s[ch] = PEND0;
                        cnt_s[ch]   = CNT_ONE;
                    end else begin
                        cnt_s[ch]   = CNT_ZERO;
                    end
                end
                PEND0: begin
                    if (!sync2_r[ch] && (cnt_r[ch] == CNT_LAST)) begin
                        state_s[ch] = STABLE0;
                        cnt_s[ch]   = CNT_ZERO;
                        level_s[ch] = 1'b0;
                    end else if (!sync2_r[ch]) begin
                        cnt_s[ch]   = cnt_r[ch] + CNT_ONE;
                    end else begin
                        state_s[ch] = STABLE1;
                        cnt_s[ch]   = CNT_ZERO;
                    end
                end
                default: begin
                    state_s[ch] = STABLE0;
                    cnt_s[ch]   = CNT_ZERO;
                    level_s[ch] = 1'b0;
                end
            endcase
        end

        if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_s = TICK_ZERO;
        end else begin
            tick_cnt_s = tick_cnt_r + TICK_ONE;
        end
    end

    // State, counters and registered outputs; rise pulses fire with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= STABLE0;
                cnt_r[ch]   <= CNT_ZERO;
            end
            level_r    <= 2'b00;
            rise_r     <= 2'b00;
            tick_cnt_r <= TICK_ZERO;
            tick_r     <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= state_s[ch];
                cnt_r[ch]   <= cnt_s[ch];
            end
            level_r    <= level_s;
            rise_r     <= level_s & ~level_r;
            tick_cnt_r <= tick_cnt_s;
            tick_r     <= (tick_cnt_s == TICK_LAST);
        end
    end

    assign left       = level_r[0];
    assign right      = level_r[1];
    assign left_rise  = rise_r[0];
    assign right_rise = rise_r[1];
    assign tick       = tick_r;

endmodule

// File: doc/turn_signal_conditioner.md
TURN_SIGNAL_CONDITIONER -- requirements
Module: turn_signal_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-sample edges a new switch level must persist before it is accepted; legal range 1 and up.
REQ-002 Parameter TICK_DIV, default 8: step-tick period in clk cycles; legal range 2 and up.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port left_raw, input, 1 bit: raw, asynchronous, bouncing left turn switch.
REQ-006 Port right_raw, input, 1 bit: raw, asynchronous, bouncing right turn switch.
REQ-007 Port left, output, 1 bit: debounced left level, registered; drives the tail-light sequencer's left input.
REQ-008 Port right, output, 1 bit: debounced right level, registered; drives the sequencer's right input.
REQ-009 Port left_rise, output, 1 bit: one-cycle pulse in the first cycle left reads 1.
REQ-010 Port right_rise, output, 1 bit: one-cycle pulse in the first cycle right reads 1.
REQ-011 Port tick, output, 1 bit: free-running step enable, high for exactly one cycle every TICK_DIV cycles.

Function
REQ-012 Each raw input SHALL pass through its own two-flop synchronizer before any other logic sees it.
REQ-013 Each channel SHALL run an independent four-state debounce FSM: STABLE0, PEND1, STABLE1, PEND0.
REQ-014 STABLE0 SHALL go to PEND1 when the synchronized value is 1; otherwise it holds.
REQ-015 PEND1 SHALL count consecutive edges with synchronized value 1, and return to STABLE0 with the count cleared on any 0 sample.
REQ-016 PEND1 SHALL go to STABLE1 on the DEBOUNCE_CYCLES-th consecutive 1 edge, setting the output to 1 on that same edge.
REQ-017 STABLE1 and PEND0 SHALL mirror STABLE0 and PEND1 with values inverted, clearing the output to 0 on acceptance.
REQ-018 The debounce counter SHALL be sized to hold DEBOUNCE_CYCLES and SHALL clear on every return to a STABLE state.
REQ-019 Accepted-level latency SHALL be exactly 2+DEBOUNCE_CYCLES rising edges, counting the edge that first samples the new raw level.
REQ-020 With default parameters, that latency SHALL be the 6th edge.
REQ-021 A raw pulse or gap shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change and no rise pulse.
REQ-022 left_rise and right_rise SHALL be registered and assert in the same cycle their level output first reads 1.
REQ-023 Rise pulses SHALL deassert after exactly one cycle; a falling acceptance SHALL produce no pulse.
REQ-024 The two channels SHALL be fully independent; simultaneous or overlapping activity on both SHALL yield both outputs and both pulses with no arbitration.
REQ-025 The tick counter SHALL run 0..TICK_DIV-1 and wrap to 0.
REQ-026 tick SHALL be high exactly while the tick counter equals TICK_DIV-1, independent of all switch activity.

Reset
REQ-027 Asserting reset SHALL immediately force left, right, left_rise, right_rise, tick and all synchronizer flops to 0.
REQ-028 Asserting reset SHALL also force both FSMs to STABLE0, both debounce counters to 0 and the tick counter to 0.
REQ-029 Reset asserted mid-debounce SHALL discard the pending count; after release, a held input SHALL require the full 2+DEBOUNCE_CYCLES edges again.
REQ-030 After reset release, tick SHALL first assert after the (TICK_DIV-1)-th rising edge, then every TICK_DIV cycles.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-031 Reset, then release, raws low -> all outputs 0; tick high after edges 7, 15, 23, each for one cycle.
REQ-032 left_raw 0->1 and held -> left=1 after the 6th edge, with left_rise=1 for that single cycle only; right and right_rise stay 0.
REQ-033 right_raw high for 3 cycles, then low -> right and right_rise stay 0 throughout.
REQ-034 right_raw toggles every 2 cycles for 10 cycles, then held 1 -> right=1 on the 6th edge after the final 0->1 raw change, with one right_rise pulse.
REQ-035 left_raw held 1, reset asserted for 1 cycle after the 4th edge, then released -> left=0 during reset; left=1 on the 6th edge after release.
REQ-036 left_raw and right_raw rise on the same edge -> left, right, left_rise and right_rise all assert on the same 6th edge.
